lbist_session_ctrl: RTL and testbench

Power-on self-test sequencer for the RI5CY core with built-in LBIST. It sits between the testbench/SoC top and the core's test pins. On request it:
- holds the core in reset in test configuration;
- releases it to run LBIST and waits for `test_over`, with a timeout;
- judges `go_nogo`.

On pass it re-resets the core into functional mode and forwards fetch enable. On fail it parks the core in reset.

---
 rtl/lbist_ctrl_pkg.sv | 42 ++++
 rtl/lbist_session_ctrl.sv | 158 +++++++++++++++
 tb/tb_lbist_session_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lbist_ctrl_pkg.sv
// Shared types for the LBIST power-on session controller: state encoding,
// default timing constants and the core test-pin bundle with its state decode.
package lbist_ctrl_pkg;

  localparam int unsigned DEF_RST_HOLD_CYCLES = 4;
  localparam int unsigned DEF_SETTLE_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 65536;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_RST,
    S_SETUP,
    S_RUN,
    S_EVAL,
    S_F_RST,
    S_FUNC,
    S_FAIL
  } lbist_state_e;

  typedef struct packed {
    logic rst_n;
    logic clk_en;
    logic test_mode;
    logic test_mode_tp;
    logic normal_test;
  } core_pins_t;

  // EVAL keeps the RUN pin values so the core is undisturbed while the verdict is judged.
  function automatic core_pins_t pins_decode(lbist_state_e s);
    core_pins_t p;
    p = '{rst_n: 1'b0, clk_en: 1'b0, test_mode: 1'b0, test_mode_tp: 1'b0, normal_test: 1'b1};
    case (s)
      S_T_RST:                p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      S_SETUP, S_RUN, S_EVAL: p = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      S_F_RST:                p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      S_FUNC:                 p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      default:                p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lbist_session_ctrl.sv
// Power-on self-test sequencer: test-mode reset, LBIST run with timeout, verdict,
// then functional reset and gated fetch enable (or park in reset on failure).
module lbist_session_ctrl
  import lbist_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic bist_en_i,
  input  logic fetch_enable_i,
  input  logic core_test_over_i,
  input  logic core_go_nogo_i,
  output logic core_rst_no,
  output logic core_clock_en_o,
  output logic core_test_mode_o,
  output logic core_test_mode_tp_o,
  output logic core_normal_test_o,
  output logic core_fetch_enable_o,
  output logic busy_o,
  output logic done_o,
  output logic pass_o,
  output logic timeout_o
);

  localparam int unsigned MAX_AB = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);

  lbist_state_e     r_state;
  lbist_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_verdict;
  logic             w_verdict_nxt;
  logic             w_timeout_evt;
  logic             w_cnt_zero;
  core_pins_t       r_pins;
  logic             r_fetch;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_verdict_nxt = r_verdict;
    w_timeout_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = bist_en_i ? S_T_RST : S_F_RST;
          w_cnt_nxt   = HOLD_LD;
        end
      end
      S_T_RST: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      // test_over is deliberately not looked at here: it may still be high from a previous run.
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = TMO_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (core_test_over_i) begin
          w_state_nxt   = S_EVAL;
          w_verdict_nxt = core_go_nogo_i;
          w_cnt_nxt     = '0;
        end else if (w_cnt_zero) begin
          w_state_nxt   = S_FAIL;
          w_timeout_evt = 1'b1;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_EVAL: begin
        if (r_verdict) begin
          w_state_nxt = S_F_RST;
          w_cnt_nxt   = HOLD_LD;
        end else begin
          w_state_nxt = S_FAIL;
          w_cnt_nxt   = '0;
        end
      end
      S_F_RST: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FUNC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_verdict <= 1'b0;
      r_pins    <= pins_decode(S_IDLE);
      r_fetch   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_verdict <= w_verdict_nxt;
      r_pins    <= pins_decode(w_state_nxt);
      r_fetch   <= (w_state_nxt == S_FUNC) && fetch_enable_i;
      r_busy    <= (w_state_nxt == S_T_RST) || (w_state_nxt == S_SETUP) ||
                   (w_state_nxt == S_RUN)   || (w_state_nxt == S_EVAL)  ||
                   (w_state_nxt == S_F_RST);
      r_done    <= (w_state_nxt == S_FUNC) || (w_state_nxt == S_FAIL);
      r_pass    <= (w_state_nxt == S_FUNC);
      r_timeout <= r_timeout || w_timeout_evt;
    end
  end

  assign core_rst_no         = r_pins.rst_n;
  assign core_clock_en_o     = r_pins.clk_en;
  assign core_test_mode_o    = r_pins.test_mode;
  assign core_test_mode_tp_o = r_pins.test_mode_tp;
  assign core_normal_test_o  = r_pins.normal_test;
  assign core_fetch_enable_o = r_fetch;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign pass_o              = r_pass;
  assign timeout_o           = r_timeout;

endmodule

// File: tb/tb_lbist_session_ctrl.sv
// Scoreboard bench for lbist_session_ctrl: a session-level model predicts each output
// change (edge number and full output vector); a negedge monitor pops and compares.
module tb_lbist_session_ctrl;

  localparam int H = 4;
  localparam int S = 2;
  localparam int T = 8;

  // Output vector: {rst_n, clk_en, test_mode, tp, normal_test, fetch, busy, done, pass, timeout}
  localparam logic [9:0] V_RST   = {5'b00001, 1'b0, 4'b0000};
  localparam logic [9:0] V_TRST  = {5'b01110, 1'b0, 4'b1000};
  localparam logic [9:0] V_SETUP = {5'b11110, 1'b0, 4'b1000};
  localparam logic [9:0] V_FRST  = {5'b01001, 1'b0, 4'b1000};

  function automatic logic [9:0] v_func(logic fe);
    return {5'b11001, fe, 4'b0110};
  endfunction

  function automatic logic [9:0] v_fail(logic to);
    return {5'b00001, 1'b0, 3'b010, to};
  endfunction

  logic clk;
  logic rst_ni;
  logic start_i;
  logic bist_en_i;
  logic fetch_enable_i;
  logic core_test_over_i;
  logic core_go_nogo_i;
  logic core_rst_no;
  logic core_clock_en_o;
  logic core_test_mode_o;
  logic core_test_mode_tp_o;
  logic core_normal_test_o;
  logic core_fetch_enable_o;
  logic busy_o;
  logic done_o;
  logic pass_o;
  logic timeout_o;

  lbist_session_ctrl #(
    .RST_HOLD_CYCLES(H),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .bist_en_i          (bist_en_i),
    .fetch_enable_i     (fetch_enable_i),
    .core_test_over_i   (core_test_over_i),
    .core_go_nogo_i     (core_go_nogo_i),
    .core_rst_no        (core_rst_no),
    .core_clock_en_o    (core_clock_en_o),
    .core_test_mode_o   (core_test_mode_o),
    .core_test_mode_tp_o(core_test_mode_tp_o),
    .core_normal_test_o (core_normal_test_o),
    .core_fetch_enable_o(core_fetch_enable_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .pass_o             (pass_o),
    .timeout_o          (timeout_o)
  );

  logic [9:0] w_vec;
  assign w_vec = {core_rst_no, core_clock_en_o, core_test_mode_o, core_test_mode_tp_o,
                  core_normal_test_o, core_fetch_enable_o, busy_o, done_o, pass_o, timeout_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] v;
  } ev_t;

  ev_t        q[$];
  logic [9:0] last_v = V_RST;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Record an expected output vector from edge 'at' on; only real changes become events.
  task automatic exp_at(input int at, input logic [9:0] v);
    ev_t e;
    if (v != last_v) begin
      e.at = at;
      e.v  = v;
      q.push_back(e);
      last_v = v;
    end
  endtask

  logic [9:0] mon_prev = V_RST;
  always @(negedge clk) begin
    ev_t e;
    if (w_vec !== mon_prev) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_change: got %0h previous %0h (cycle %0d)", w_vec, mon_prev, cyc);
      end else begin
        e = q.pop_front();
        check("event_vector", 32'(w_vec), 32'(e.v));
        check("event_cycle", cyc, e.at);
      end
    end
    mon_prev = w_vec;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_at(cyc, V_RST);
    rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", 32'(w_vec), 32'(V_RST));
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("reset_events_drained", q.size(), 0);
  endtask

  // One session. j = RUN cycle on which test_over is seen (0 = never); noise: 0 low,
  // 1 random, 2 held high for test_over before RUN; abort_at > 0 stops after that many RUN cycles.
  task automatic run_session(input bit bist, input int j, input bit g, input int noise,
                             input int abort_at);
    int k, r, fin;
    bit is_pass;
    logic fe0;
    fe0 = 1'($urandom_range(0, 1));
    fetch_enable_i = fe0;
    start_i   = 1'b1;
    bist_en_i = bist;
    tick();
    k = cyc;
    start_i   = 1'b0;
    bist_en_i = 1'($urandom_range(0, 1));
    is_pass = 1'b0;
    r = k + H + S;
    fin = k + H;
    if (!bist) begin
      exp_at(k, V_FRST);
      exp_at(k + H, v_func(fe0));
      is_pass = 1'b1;
    end else begin
      exp_at(k, V_TRST);
      exp_at(k + H, V_SETUP);
      if (abort_at == 0) begin
        if (j >= 1 && j <= T) begin
          if (g) begin
            exp_at(r + j + 1, V_FRST);
            exp_at(r + j + 1 + H, v_func(fe0));
            fin = r + j + 1 + H;
            is_pass = 1'b1;
          end else begin
            exp_at(r + j + 1, v_fail(1'b0));
            fin = r + j + 1;
          end
        end else begin
          exp_at(r + T, v_fail(1'b1));
          fin = r + T;
        end
      end else begin
        fin = r + abort_at - 1;
      end
      while (cyc + 1 <= r) begin
        core_test_over_i = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        core_go_nogo_i   = 1'($urandom_range(0, 1));
        start_i          = 1'($urandom_range(0, 1));
        tick();
      end
    end
    while (cyc < fin + 1) begin
      core_test_over_i = bist ? (cyc + 1 == r + j) : 1'($urandom_range(0, 1));
      core_go_nogo_i   = (bist && cyc + 1 == r + j) ? g : 1'($urandom_range(0, 1));
      start_i          = 1'($urandom_range(0, 1));
      tick();
    end
    core_test_over_i = 1'b0;
    start_i          = 1'b0;
    if (abort_at == 0) begin
      repeat (10) begin
        if (is_pass) begin
          fetch_enable_i = 1'($urandom_range(0, 1));
          exp_at(cyc + 1, v_func(fetch_enable_i));
        end
        start_i   = 1'($urandom_range(0, 1));
        bist_en_i = 1'($urandom_range(0, 1));
        tick();
      end
      start_i = 1'b0;
      repeat (2) tick();
      check("session_events_drained", q.size(), 0);
    end
  endtask

  initial begin
    rst_ni           = 1'b0;
    start_i          = 1'b0;
    bist_en_i        = 1'b0;
    fetch_enable_i   = 1'b0;
    core_test_over_i = 1'b0;
    core_go_nogo_i   = 1'b0;
    repeat (3) tick();
    check("reset_state", 32'(w_vec), 32'(V_RST));
    rst_ni = 1'b1;
    tick();
    tick();
    check("idle_state", 32'(w_vec), 32'(V_RST));

    run_session(1'b1, 5, 1'b1, 0, 0);     do_reset();
    run_session(1'b1, 5, 1'b0, 0, 0);     do_reset();
    run_session(1'b1, 0, 1'b1, 0, 0);     do_reset();
    run_session(1'b1, T, 1'b1, 0, 0);     do_reset();
    run_session(1'b1, T, 1'b0, 0, 0);     do_reset();
    run_session(1'b1, T + 1, 1'b1, 0, 0); do_reset();
    run_session(1'b1, 1, 1'b1, 2, 0);     do_reset();
    run_session(1'b1, 3, 1'b1, 1, 0);     do_reset();
    run_session(1'b0, 0, 1'b0, 1, 0);     do_reset();
    run_session(1'b1, 6, 1'b1, 0, 3);     do_reset();
    run_session(1'b1, 4, 1'b1, 0, 0);     do_reset();

    for (int i = 0; i < 14; i++) begin
      run_session(($urandom_range(0, 3) != 0), int'($urandom_range(0, T + 2)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
      do_reset();
    end

    repeat (3) tick();
    check("final_events_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
